// File: rtl/fpga2_receiver_pkg.sv
// Shared definitions for the FPGA1 -> FPGA2 word-burst link, receiving side.
package fpga2_receiver_pkg;

    // Width of one link word.
    localparam int LINK_DW = 32;

    // Words per frame; the sender's SEND_COUNT must use the same value.
    localparam int SEND_COUNT_DEFAULT = 10;

    // Receiver control states.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READY   = 3'd1,
        S_RECEIVE = 3'd2,
        S_ACK     = 3'd3,
        S_NACK    = 3'd4,
        S_DRAIN   = 3'd5
    } rx_state_t;

endpackage

// File: rtl/rx_ring_buf.sv
// Ring storage for received link words: synchronous write, combinational read.
module rx_ring_buf #(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];

    // Capture one word per write strobe.
    // NOTE: the array has no reset; a frame is only read after it has been written.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fpga2_receiver.sv
// Receiving end of the word-burst link: captures a burst into a ring, checks
// the word count on the send_done edge, ACKs or NACKs, then streams the frame.
module fpga2_receiver
    import fpga2_receiver_pkg::*;
#(
    parameter int RECV_COUNT = SEND_COUNT_DEFAULT,
    parameter int TAIL_SKIP  = 1,
    parameter int BUF_AW     = 4,
    parameter int TIMEOUT    = 1024,
    parameter int NACK_HOLD  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               req_in,
    input  logic [LINK_DW-1:0] data_in,
    input  logic               send_done_in,
    output logic               rdy_out,
    output logic               ack_out,
    output logic [LINK_DW-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               done,
    output logic               nack
);

    localparam int CNT_W  = BUF_AW + 1;
    localparam int TMR_W  = $clog2(TIMEOUT + 1);
    localparam int DRN_W  = $clog2(RECV_COUNT + 1);
    localparam int HOLD_W = $clog2(NACK_HOLD);

    localparam logic [CNT_W-1:0]  CNT_NEED  = CNT_W'(RECV_COUNT + TAIL_SKIP);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(2**BUF_AW);
    localparam logic [BUF_AW-1:0] RD_BACK   = BUF_AW'(RECV_COUNT + TAIL_SKIP);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [DRN_W-1:0]  DRN_LAST  = DRN_W'(RECV_COUNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(NACK_HOLD - 1);

    rx_state_t          state_q, state_d;
    logic [BUF_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [BUF_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [DRN_W-1:0]   drn_q, drn_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               sd_q;

    logic               rdy_q, rdy_d;
    logic               ack_q, ack_d;
    logic               valid_q, valid_d;
    logic [LINK_DW-1:0] data_q, data_d;
    logic               done_q, done_d;
    logic               nack_q, nack_d;

    logic               buf_we;
    logic [LINK_DW-1:0] buf_rdata;
    logic               sd_rise;

    assign sd_rise = send_done_in & ~sd_q;

    rx_ring_buf #(
        .AW (BUF_AW),
        .DW (LINK_DW)
    ) u_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .raddr_i (rd_ptr_d),
        .rdata_o (buf_rdata)
    );

    // Next-state, pointer/counter updates and registered-output values.
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        tmr_d    = tmr_q;
        drn_d    = drn_q;
        hold_d   = '0;
        buf_we   = 1'b0;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (en) state_d = S_READY;
            end
            S_READY: begin
                cnt_d = '0;
                tmr_d = '0;
                if (req_in) state_d = S_RECEIVE;
            end
            S_RECEIVE: begin
                if (sd_rise) begin
                    // The edge-cycle sample is the sender's repeat; never stored.
                    if (cnt_q >= CNT_NEED) begin
                        state_d  = S_ACK;
                        rd_ptr_d = wr_ptr_q - RD_BACK;
                    end else begin
                        state_d = S_NACK;
                    end
                end else begin
                    buf_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    tmr_d    = tmr_q + 1'b1;
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                    if (!req_in || tmr_q == TMR_LAST) state_d = S_NACK;
                end
            end
            S_ACK: begin
                drn_d = '0;
                if (!req_in) state_d = S_DRAIN;
            end
            S_NACK: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = en ? S_READY : S_IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (valid_q && out_ready) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    drn_d    = drn_q + 1'b1;
                    if (drn_q == DRN_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs follow the next state so they change on the deciding edge.
        rdy_d   = (state_d == S_READY) || (state_d == S_RECEIVE) || (state_d == S_ACK);
        ack_d   = (state_d == S_ACK);
        valid_d = (state_d == S_DRAIN);
        nack_d  = (state_d == S_NACK) && (state_q != S_NACK);
        data_d  = (state_d == S_DRAIN) ? buf_rdata : data_q;
    end

    // State, pointer, counter and output registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            tmr_q    <= '0;
            drn_q    <= '0;
            hold_q   <= '0;
            sd_q     <= 1'b0;
            rdy_q    <= 1'b0;
            ack_q    <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
            nack_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
            drn_q    <= drn_d;
            hold_q   <= hold_d;
            sd_q     <= send_done_in;
            rdy_q    <= rdy_d;
            ack_q    <= ack_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            done_q   <= done_d;
            nack_q   <= nack_d;
        end
    end

    assign rdy_out   = rdy_q;
    assign ack_out   = ack_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign done      = done_q;
    assign nack      = nack_q;

endmodule

// File: tb/tb_fpga2_receiver.sv
// Self-checking bench for fpga2_receiver: directed and random frames against a
// model that keeps the words driven during a burst and picks the frame from them.
module tb_fpga2_receiver;

    localparam int RECV_COUNT = 10;
    localparam int TAIL_SKIP  = 1;
    localparam int BUF_AW     = 4;
    localparam int TIMEOUT    = 16;
    localparam int NACK_HOLD  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        req_in = 1'b0;
    logic [31:0] data_in = '0;
    logic        send_done_in = 1'b0;
    logic        out_ready = 1'b0;
    logic        rdy_out, ack_out, out_valid, done, nack;
    logic [31:0] out_data;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] frame_q[$];   // words driven on capture cycles before the edge
    logic [31:0] exp_q[$];     // frame the model expects on the output stream
    bit          exp_ack;

    fpga2_receiver #(
        .RECV_COUNT (RECV_COUNT),
        .TAIL_SKIP  (TAIL_SKIP),
        .BUF_AW     (BUF_AW),
        .TIMEOUT    (TIMEOUT),
        .NACK_HOLD  (NACK_HOLD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .req_in       (req_in),
        .data_in      (data_in),
        .send_done_in (send_done_in),
        .rdy_out      (rdy_out),
        .ack_out      (ack_out),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .done         (done),
        .nack         (nack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Advance one clock; outputs are sampled and inputs driven 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdy"},   rdy_out,   0);
        check({tag, "_ack"},   ack_out,   0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"},  out_data,  0);
        check({tag, "_done"},  done,      0);
        check({tag, "_nack"},  nack,      0);
    endtask

    // Drive one burst from frame_q, then the send_done edge; the model decides ACK/NACK.
    task automatic run_frame();
        int base;
        req_in  = 1'b1;
        data_in = 32'hDEAD_BEEF;   // seen in READY only, never captured
        step();
        foreach (frame_q[i]) begin
            check("rx_rdy", rdy_out, 1);
            check("rx_ack", ack_out, 0);
            data_in = frame_q[i];
            step();
        end
        send_done_in = 1'b1;
        data_in      = $urandom;
        step();
        exp_ack = (frame_q.size() >= RECV_COUNT + TAIL_SKIP);
        exp_q.delete();
        if (exp_ack) begin
            base = frame_q.size() - TAIL_SKIP - RECV_COUNT;
            for (int i = 0; i < RECV_COUNT; i++) exp_q.push_back(frame_q[base + i]);
        end
        check("edge_ack",  ack_out, {31'b0, exp_ack});
        check("edge_nack", nack,    {31'b0, !exp_ack});
        check("edge_rdy",  rdy_out, {31'b0, exp_ack});
    endtask

    // After a NACK edge: ready stays low for NACK_HOLD cycles, then returns.
    task automatic nack_recover();
        req_in       = 1'b0;
        send_done_in = 1'b0;
        for (int i = 1; i < NACK_HOLD; i++) begin
            step();
            check("nack_rdy_low",  rdy_out,   0);
            check("nack_one_shot", nack,      0);
            check("nack_no_valid", out_valid, 0);
        end
        step();
        check("nack_back_ready", rdy_out, 1);
    endtask

    // Hold ACK briefly, drop req, then drain with the chosen out_ready pattern.
    // mode 0: always ready, 1: 1,0,0 repeating, 2: random. abort_at>0 resets mid-drain.
    task automatic ack_and_drain(input int mode, input int abort_at);
        int   idx = 0;
        int   cyc = 0;
        logic r;
        send_done_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("ack_held",      ack_out,   1);
            check("ack_rdy",       rdy_out,   1);
            check("ack_no_valid",  out_valid, 0);
        end
        req_in = 1'b0;
        step();
        check("drain_ack_drop", ack_out, 0);
        check("drain_rdy_low",  rdy_out, 0);
        while (idx < RECV_COUNT) begin
            if (cyc == 200) begin
                check("drain_budget", idx, RECV_COUNT);
                break;
            end
            if (abort_at != 0 && idx == abort_at) begin
                out_ready = 1'b0;
                rst_n     = 1'b0;
                step();
                check_all_zero("mid_drain_reset");
                rst_n = 1'b1;
                step();
                check("post_reset_ready", rdy_out, 1);
                return;
            end
            check("drain_valid", out_valid, 1);
            check("drain_data",  out_data,  exp_q[idx]);
            check("drain_done",  done,      0);
            check("drain_nack",  nack,      0);
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready = r;
            step();
            if (r) idx++;
            cyc++;
        end
        out_ready = 1'b0;
        check("done_pulse",     done,      1);
        check("done_valid_low", out_valid, 0);
        step();
        check("done_one_cycle", done,    0);
        check("back_to_ready",  rdy_out, 1);
    endtask

    initial begin
        int len;

        // Reset state.
        step();
        step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();
        check("idle_without_en", rdy_out, 0);
        en = 1'b1;
        step();
        check("ready_rdy", rdy_out, 1);
        check("ready_ack", ack_out, 0);

        // Nominal frame: junk, 0x100..0x109, repeated last word.
        frame_q.delete();
        frame_q.push_back(32'hDEAD);
        for (int i = 0; i < RECV_COUNT; i++) frame_q.push_back(32'h100 + i);
        frame_q.push_back(32'h109);
        run_frame();
        ack_and_drain(0, 0);

        // Short frame: five words plus repeat.
        frame_q.delete();
        for (int i = 0; i < 5; i++) frame_q.push_back(32'h50 + i);
        frame_q.push_back(32'h54);
        run_frame();
        nack_recover();

        // Full frame after the NACK.
        frame_q.delete();
        for (int i = 0; i < RECV_COUNT; i++) frame_q.push_back(32'h300 + i);
        frame_q.push_back(32'h309);
        run_frame();
        ack_and_drain(0, 0);

        // One sample short of the threshold.
        frame_q.delete();
        for (int i = 0; i < RECV_COUNT - 1; i++) frame_q.push_back(32'h600 + i);
        frame_q.push_back(32'h608);
        run_frame();
        nack_recover();

        // Abort: req drops after three words.
        req_in  = 1'b1;
        data_in = 32'hDEAD_BEEF;
        step();
        for (int i = 0; i < 3; i++) begin
            data_in = 32'h700 + i;
            step();
        end
        req_in = 1'b0;
        step();
        check("abort_nack",  nack,      1);
        check("abort_rdy",   rdy_out,   0);
        check("abort_valid", out_valid, 0);
        nack_recover();

        // Timeout with send_done held high from before the frame (no edge).
        send_done_in = 1'b1;
        step();
        check("hold_sd_ready", rdy_out, 1);
        req_in = 1'b1;
        step();
        for (int i = 1; i < TIMEOUT; i++) begin
            data_in = $urandom;
            step();
            check("timeout_wait_nack", nack,    0);
            check("timeout_wait_rdy",  rdy_out, 1);
        end
        step();
        check("timeout_nack", nack,    1);
        check("timeout_rdy",  rdy_out, 0);
        nack_recover();

        // Backpressure 1,0,0 during drain.
        frame_q.delete();
        for (int i = 0; i < RECV_COUNT; i++) frame_q.push_back(32'h400 + i);
        frame_q.push_back(32'h409);
        run_frame();
        ack_and_drain(1, 0);

        // Reset after four transfers, then a clean frame.
        frame_q.delete();
        for (int i = 0; i < RECV_COUNT; i++) frame_q.push_back(32'h500 + i);
        frame_q.push_back(32'h509);
        run_frame();
        ack_and_drain(0, 4);
        frame_q.delete();
        frame_q.push_back(32'hDEAD);
        for (int i = 0; i < RECV_COUNT; i++) frame_q.push_back(32'h200 + i);
        frame_q.push_back(32'h209);
        run_frame();
        ack_and_drain(0, 0);

        // Random frames around the length threshold, random backpressure.
        for (int k = 0; k < 8; k++) begin
            len = $urandom_range(RECV_COUNT - 1, RECV_COUNT + 3);
            frame_q.delete();
            for (int i = 0; i < len - 1; i++) frame_q.push_back($urandom);
            frame_q.push_back(frame_q[len - 2]);
            run_frame();
            if (exp_ack) ack_and_drain(2, 0);
            else         nack_recover();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fpga2_receiver.md
# fpga2_receiver

Receiving end of the FPGA1→FPGA2 word-burst link; runs on FPGA 2. It offers readiness to the remote sender and captures the burst of 32-bit words into a ring buffer. It delimits the frame on the sender's `send_done` strobe and validates the word count, then either acknowledges (ACK) or forces a resend by withdrawing ready (NACK). Accepted frames are streamed to the next local process over a valid/ready port.

## Interface
Parameters:
- `RECV_COUNT`, 10: words per frame; must equal sender `SEND_COUNT`.
- `TAIL_SKIP`, 1: samples immediately before the `send_done_in` edge that are discarded (sender repeats its last word).
- `BUF_AW`, 4: ring buffer address width; requires `RECV_COUNT + TAIL_SKIP <= 2**BUF_AW`.
- `TIMEOUT`, 1024: max cycles in RECEIVE before NACK.
- `NACK_HOLD`, 4: cycles `rdy_out` is held low on NACK; must be ≥ 2.

Ports:
- `clk` in 1: single clock. The link is source-synchronous to it, so there are no synchronizers.
- `rst_n` in 1: synchronous, active-low reset.
- `en` in 1: local permission to accept a frame.
- `req_in` in 1: request from FPGA 1.
- `data_in` in 32: link data from FPGA 1.
- `send_done_in` in 1: end-of-burst strobe from FPGA 1; only its rising edge is meaningful.
- `rdy_out` out 1: ready to FPGA 1.
- `ack_out` out 1: acknowledge to FPGA 1.
- `out_data` out 32: frame word to local consumer.
- `out_valid` out 1 / `out_ready` in 1: local stream handshake.
- `done` out 1: one-cycle pulse after the last word of a frame is transferred.
- `nack` out 1: one-cycle pulse on every rejected frame.

## Operation
States:
- **IDLE**
  - `rdy_out` = 0, `ack_out` = 0.
  - `en` = 1 → READY.
- **READY**
  - `rdy_out` = 1.
  - `req_in` = 1 → RECEIVE.
  - On entry: sample count = 0, write pointer kept as is, overflow/timer cleared.
- **RECEIVE**
  - `rdy_out` = 1.
  - On every cycle where there is no `send_done_in` rising edge: write `data_in` to `buf[wr_ptr]`, `wr_ptr` increments mod 2**BUF_AW, sample count increments and saturates at 2**BUF_AW.
  - Rising edge (`send_done_in` = 1, previous = 0):
    - sample count ≥ `RECV_COUNT+TAIL_SKIP` → ACK. Latch `rd_ptr = wr_ptr − TAIL_SKIP − RECV_COUNT` (mod 2**BUF_AW).
    - Otherwise → NACK.
    - The edge-cycle sample is not written.
  - `req_in` = 0 before the edge → NACK.
  - Timer reaches `TIMEOUT` → NACK.
  - The edge check has priority over the `req_in`/timeout checks in the same cycle.
- **ACK**
  - `rdy_out` = 1, `ack_out` = 1, held until `req_in` = 0, then → DRAIN.
  - `ack_out` drops in the same cycle as the transition.
- **NACK**
  - `rdy_out` = 0, `ack_out` = 0 for `NACK_HOLD` cycles; `nack` pulses on the first cycle.
  - Then → READY if `en` = 1, else IDLE.
  - The sender sees `!rdy` while awaiting ack and restarts.
- **DRAIN**
  - `rdy_out` = 0.
  - Presents `buf[rd_ptr]` with `out_valid` = 1. Each `out_valid & out_ready` advances `rd_ptr` and the drain count.
  - After `RECV_COUNT` transfers: `done` pulses for one cycle → IDLE.
- Older samples in the ring are overwritten freely. Only the last `RECV_COUNT+TAIL_SKIP` samples before the edge matter, so leading junk words are harmless.

## Timing
- Reset values of all outputs are 0: `rdy_out`, `ack_out`, `out_valid`, `out_data`, `done`, `nack`. State = IDLE; pointers, counters and the edge register are 0.
- All outputs are registered, so a transition decided at edge n is visible at edge n.
- A `send_done_in` edge at cycle t gives `ack_out` = 1 at t+1.
- `req_in` falling at cycle u gives DRAIN at u+1, with the first `out_valid` at u+1.
- With `out_ready` held high, DRAIN takes `RECV_COUNT` cycles. `done` is asserted the cycle after the last transfer, with `out_valid` = 0 on that cycle.
- `out_data` is stable while `out_valid & !out_ready`.
- `send_done_in` held high (no new edge) never ends a frame; timeout then applies.
- Reset mid-frame or mid-drain: next cycle is IDLE with outputs 0; the buffered frame is discarded.

## Structure
- Shared package holds: state encoding (IDLE, READY, RECEIVE, ACK, NACK, DRAIN), link word width 32, and the protocol default 10 shared with the sender's `SEND_COUNT`.
- One sub-module: `rx_ring_buf`, a 2**BUF_AW × 32 simple dual-port register array with synchronous write and combinational read. The FSM, counters and pointers stay in `fpga2_receiver`.

## Test plan
- **Nominal frame:** `req_in`, one junk word 0xDEAD, then 0x100..0x109, then 0x109 repeated, then `send_done_in` edge → `ack_out` next cycle. Drop `req_in` → `out_data` 0x100..0x109 in order, one `done` pulse, `nack` never set.
- **Short frame:** 5 words then edge → `nack` pulse, `rdy_out` low for exactly 4 cycles. Re-run a full 10-word frame → ACK and correct drain.
- **Abort:** `req_in` falls after 3 words → NACK and no output stream.
- **Timeout:** `TIMEOUT`=16, `req_in` = 1 with no edge → NACK on cycle 16 of RECEIVE.
- **Backpressure:** during drain, toggle `out_ready` 1,0,0,1,… → no word lost or duplicated; `out_data` held while stalled.
- **Reset mid-drain:** `rst_n` = 0 after 4 transfers → all outputs 0 next cycle. A following frame of 0x200..0x209 drains correctly.
